// File: rtl/imem_boot_loader.sv
// Streams 32-bit program words into instruction memory from a programmable base
// address, owning the memory write port and stalling fetch while it loads.
module imem_boot_loader #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [AWIDTH-1:0] cfg_base,
  input  logic [AWIDTH-2:0] cfg_count,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] cpu_addr,
  output logic [DWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_data,
  output logic              mem_we,
  output logic              cpu_stall,
  output logic              done,
  output logic              err,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int WORDS = 2 ** (AWIDTH - 2);

  state_t            state;
  logic [AWIDTH-1:0] ptr;
  logic [AWIDTH-2:0] rem;
  logic [AWIDTH-1:0] wr_addr;
  logic [DWIDTH-1:0] wr_data;
  logic              wr_pend;
  logic [AWIDTH-1:0] span_end;
  logic              span_bad;
  logic              handshake;

  // Word index one past the last word of the requested load; must not exceed the memory depth.
  assign span_end = AWIDTH'(cfg_base[AWIDTH-1:2]) + AWIDTH'(cfg_count);
  assign span_bad = span_end > AWIDTH'(WORDS);

  // Handshake: in_data is consumed on a rising edge where in_valid and in_ready are
  // both high. in_ready depends on state only, never on in_valid; in the cycle abort
  // is high the beat is not consumed even though in_ready is still shown.
  assign in_ready  = (state == LOAD);
  assign handshake = in_valid & in_ready & ~abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= '0;
      rem     <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_pend <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      wr_pend <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (cfg_count == '0) begin
              done <= 1'b1;
            end else if (span_bad) begin
              err <= 1'b1;
            end else begin
              ptr   <= cfg_base & ~AWIDTH'(3);
              rem   <= cfg_count;
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
          end else if (handshake) begin
            wr_addr <= ptr;
            wr_data <= in_data;
            wr_pend <= 1'b1;
            ptr     <= ptr + AWIDTH'(4);
            rem     <= rem - (AWIDTH-1)'(1);
            if (rem == (AWIDTH-1)'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A write left pending by an abort still owns the port for its one cycle.
  assign mem_addr  = (state != IDLE || wr_pend) ? {{(DWIDTH-AWIDTH){1'b0}}, wr_addr} : cpu_addr;
  assign mem_data  = wr_data;
  assign mem_we    = wr_pend;
  assign cpu_stall = (state != IDLE) | wr_pend;
  assign dbg_state = state;

  a_we_stalls: assert property (@(posedge clk) disable iff (!rst) (mem_we |-> cpu_stall));
  a_done_err_excl: assert property (@(posedge clk) disable iff (!rst) !(done && err));

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: randomized loads checked against a
// word-list model of the expected writes, done/err pulses and stall/ready cycles.
module tb_imem_boot_loader;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort, in_valid, in_ready;
  logic          mem_we, cpu_stall, done, err;
  logic [AW-1:0] cfg_base;
  logic [AW-2:0] cfg_count;
  logic [31:0]   in_data, cpu_addr, mem_addr, mem_data;
  logic [1:0]    dbg_state;

  // Entry: {kind(0 write,1 done,2 err), cycle[29:0], addr[31:0], data[31:0]}
  logic [95:0] exp_q[$];
  logic [95:0] got_q[$];
  logic [31:0] fixed_words[$];
  bit          valid_pat[$];
  int exp_ready = 0, ready_cnt = 0, exp_stall = 0, stall_cnt = 0;
  int cyc = 0, errors = 0, checks = 0;

  imem_boot_loader #(.AWIDTH(AW), .DWIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_base(cfg_base), .cfg_count(cfg_count),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cpu_addr(cpu_addr), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_we(mem_we), .cpu_stall(cpu_stall), .done(done), .err(err),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (mem_we === 1'b1) got_q.push_back({2'd0, 30'(cyc), mem_addr, mem_data});
    if (done === 1'b1) got_q.push_back({2'd1, 30'(cyc), 64'd0});
    if (err === 1'b1) got_q.push_back({2'd2, 30'(cyc), 64'd0});
    if (in_ready === 1'b1) ready_cnt++;
    if (cpu_stall === 1'b1) stall_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (3) tick();
  endtask

  // driver + reference model: one start request and its word stream
  task automatic do_load(input logic [AW-1:0] base, input int count, input int pct,
                         input int abort_after, input bit mid_start);
    int          sent, last_k;
    bit          aborted, started_mid;
    logic [31:0] word_addr;
    sent = 0; last_k = 0; aborted = 0; started_mid = 0;
    start = 1'b1; cfg_base = base; cfg_count = (AW-1)'(count);
    if (count == 0) exp_q.push_back({2'd1, 30'(cyc + 1), 64'd0});
    else if ((int'(base) >> 2) + count > 256) exp_q.push_back({2'd2, 30'(cyc + 1), 64'd0});
    tick();
    start = 1'b0; cfg_base = AW'($urandom); cfg_count = (AW-1)'($urandom);
    if (count > 0 && (int'(base) >> 2) + count <= 256) begin
      word_addr = {22'd0, base[AW-1:2], 2'b00};
      while (sent < count && !aborted) begin
        if (valid_pat.size() > 0) in_valid = valid_pat.pop_front();
        else in_valid = ($urandom_range(0, 99) < pct);
        in_data = $urandom;
        if (in_valid && fixed_words.size() > 0) in_data = fixed_words.pop_front();
        abort = (sent == abort_after);
        if (abort) in_valid = 1'b1;
        start = mid_start && !started_mid && sent == 1 && !abort;
        if (start) started_mid = 1'b1;
        exp_ready++;
        exp_stall++;
        if (abort) aborted = 1'b1;
        else if (in_valid) begin
          exp_q.push_back({2'd0, 30'(cyc + 1), word_addr + 32'(4 * sent), in_data});
          last_k = cyc;
          sent++;
        end
        tick();
      end
      in_valid = 1'b0; abort = 1'b0; start = 1'b0;
      if (!aborted) begin
        exp_stall++;
        exp_q.push_back({2'd1, 30'(last_k + 2), 64'd0});
      end
    end
    tick();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    cpu_addr = $urandom;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_cpu_stall got=%b exp=0", cpu_stall); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_pulses got=%b%b exp=00", done, err); end
    checks++; if (mem_data !== 32'd0) begin errors++; $display("FAIL reset_mem_data got=%h exp=0", mem_data); end
    checks++; if (mem_addr !== cpu_addr) begin errors++; $display("FAIL reset_mem_addr got=%h exp=%h", mem_addr, cpu_addr); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    fixed_words = '{32'h13, 32'h93, 32'h113, 32'h193};
    do_load(10'h000, 4, 100, -1, 1'b0);
    settle();
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      checks++;
      if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL b2b_event got=%h exp=%h", got_q[0], exp_q[0]); end
      void'(got_q.pop_front()); void'(exp_q.pop_front());
    end
    got_q.delete(); exp_q.delete();
    checks++;
    if (stall_cnt != exp_stall || ready_cnt != exp_ready) begin
      errors++; $display("FAIL b2b_stall_ready got=%0d/%0d exp=%0d/%0d", stall_cnt, ready_cnt, exp_stall, exp_ready);
    end
  endtask

  task automatic test_gaps();
    valid_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    do_load(10'h0A4, 3, 0, -1, 1'b0);
    settle();
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL gaps_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      checks++;
      if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL gaps_event got=%h exp=%h", got_q[0], exp_q[0]); end
      void'(got_q.pop_front()); void'(exp_q.pop_front());
    end
    got_q.delete(); exp_q.delete();
    checks++;
    if (stall_cnt != exp_stall || ready_cnt != exp_ready) begin
      errors++; $display("FAIL gaps_stall_ready got=%0d/%0d exp=%0d/%0d", stall_cnt, ready_cnt, exp_stall, exp_ready);
    end
  endtask

  task automatic test_range();
    do_load(10'h3F8, 3, 100, -1, 1'b0);
    do_load(10'h3F8, 2, 100, -1, 1'b0);
    do_load(10'h3FB, 2, 70, -1, 1'b0);
    do_load(10'h004, 256, 100, -1, 1'b0);
    do_load(10'h000, 256, 100, -1, 1'b0);
    settle();
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL range_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      checks++;
      if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL range_event got=%h exp=%h", got_q[0], exp_q[0]); end
      void'(got_q.pop_front()); void'(exp_q.pop_front());
    end
    got_q.delete(); exp_q.delete();
    checks++;
    if (stall_cnt != exp_stall || ready_cnt != exp_ready) begin
      errors++; $display("FAIL range_stall_ready got=%0d/%0d exp=%0d/%0d", stall_cnt, ready_cnt, exp_stall, exp_ready);
    end
  endtask

  task automatic test_zero();
    do_load(10'h123, 0, 100, -1, 1'b0);
    abort = 1'b1;
    repeat (2) tick();
    abort = 1'b0;
    settle();
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL zero_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      checks++;
      if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL zero_event got=%h exp=%h", got_q[0], exp_q[0]); end
      void'(got_q.pop_front()); void'(exp_q.pop_front());
    end
    got_q.delete(); exp_q.delete();
    checks++;
    if (stall_cnt != exp_stall || ready_cnt != exp_ready) begin
      errors++; $display("FAIL zero_stall_ready got=%0d/%0d exp=%0d/%0d", stall_cnt, ready_cnt, exp_stall, exp_ready);
    end
  endtask

  task automatic test_abort();
    do_load(10'h200, 6, 100, 2, 1'b1);
    settle();
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL abort_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      checks++;
      if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL abort_event got=%h exp=%h", got_q[0], exp_q[0]); end
      void'(got_q.pop_front()); void'(exp_q.pop_front());
    end
    got_q.delete(); exp_q.delete();
    checks++;
    if (stall_cnt != exp_stall || ready_cnt != exp_ready) begin
      errors++; $display("FAIL abort_stall_ready got=%0d/%0d exp=%0d/%0d", stall_cnt, ready_cnt, exp_stall, exp_ready);
    end
    for (int i = 0; i < 3; i++) begin
      cpu_addr = $urandom;
      #1;
      checks++;
      if (mem_addr !== cpu_addr) begin errors++; $display("FAIL abort_passthru got=%h exp=%h", mem_addr, cpu_addr); end
      tick();
    end
  endtask

  task automatic test_random();
    int            count, ab;
    logic [AW-1:0] base;
    for (int n = 0; n < 16; n++) begin
      count = $urandom_range(0, 10);
      if ($urandom_range(0, 1) == 1) base = AW'($urandom);
      else base = AW'(32'h3D0 + $urandom_range(0, 47));
      ab = -1;
      if (count > 0 && $urandom_range(0, 3) == 0) ab = int'($urandom_range(0, count - 1));
      do_load(base, count, $urandom_range(40, 100), ab, 1'b0);
    end
    settle();
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL random_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      checks++;
      if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL random_event got=%h exp=%h", got_q[0], exp_q[0]); end
      void'(got_q.pop_front()); void'(exp_q.pop_front());
    end
    got_q.delete(); exp_q.delete();
    checks++;
    if (stall_cnt != exp_stall || ready_cnt != exp_ready) begin
      errors++; $display("FAIL random_stall_ready got=%0d/%0d exp=%0d/%0d", stall_cnt, ready_cnt, exp_stall, exp_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w0, w1;
    w0 = $urandom; w1 = $urandom;
    start = 1'b1; cfg_base = 10'h100; cfg_count = 9'd5;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = w0;
    exp_q.push_back({2'd0, 30'(cyc + 1), 32'h100, w0});
    exp_ready += 2; exp_stall += 2;
    tick();
    in_data = w1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h104 || mem_data !== w1) begin
      errors++; $display("FAIL rstmid_pending got=%b/%h/%h exp=1/%h/%h", mem_we, mem_addr, mem_data, 32'h104, w1);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || cpu_stall !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_drop got=%b%b%b exp=000", mem_we, cpu_stall, in_ready);
    end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rstmid_state got=%0d exp=0", dbg_state); end
    repeat (2) tick();
    rst = 1'b1;
    tick();
    do_load(10'h040, 3, 100, -1, 1'b0);
    do_load(10'h3F0, 4, 60, -1, 1'b0);
    settle();
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      checks++;
      if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL rstmid_event got=%h exp=%h", got_q[0], exp_q[0]); end
      void'(got_q.pop_front()); void'(exp_q.pop_front());
    end
    got_q.delete(); exp_q.delete();
    checks++;
    if (stall_cnt != exp_stall || ready_cnt != exp_ready) begin
      errors++; $display("FAIL rstmid_stall_ready got=%0d/%0d exp=%0d/%0d", stall_cnt, ready_cnt, exp_stall, exp_ready);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    cfg_base = '0; cfg_count = '0; in_data = '0; cpu_addr = '0;
    test_reset();
    test_back_to_back();
    test_gaps();
    test_range();
    test_zero();
    test_abort();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
